cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit ARM condition field against that register.
- Gates the PCS, RegWrite and MemWrite strobes, and updates the flags from the ALU's {N,Z,C,V} output according to FlagW.
- Sits between decode and writeback; outputs are registered with one-cycle latency, plus stall, flush and a saturating squash counter.

Parameters:
- FLAG_RST, 4'b0000: reset value of the flag register, ordered {N,Z,C,V}.
- CNT_W, 16: width of the squashed-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present this cycle.
- cond  input  4  instruction condition field [31:28].
- alu_flags  input  4  ALU flags {N,Z,C,V} for the current instruction.
- flag_w  input  2  [1] updates N,Z; [0] updates C,V.
- pcs_in  input  1  decoded PC-write request.
- reg_w_in  input  1  decoded register-write request.
- mem_w_in  input  1  decoded memory-write request.
- no_write_in  input  1  compare-type instruction; suppresses the register write.
- stall  input  1  hold all state.
- flush  input  1  squash the current and registered instruction.
- out_valid  output  1  registered instruction valid.
- cond_ex  output  1  registered condition result.
- pcs  output  1  gated PC write.
- reg_write  output  1  gated register write.
- mem_write  output  1  gated memory write.
- flags  output  4  architectural flag register {N,Z,C,V}.
- squash_cnt  output  CNT_W  number of valid instructions whose condition failed.

Behaviour:
- Reset, asynchronous: flags = FLAG_RST; out_valid, cond_ex, pcs, reg_write, mem_write = 0; squash_cnt = 0. Asserting reset mid-operation drops the in-flight instruction.
- Condition evaluation is combinational on cond and the current flags register, never on alu_flags. An instruction cannot see its own flag update.
- Condition codes:
  - 0000 EQ = Z; 0001 NE = ~Z
  - 0010 CS = C; 0011 CC = ~C
  - 0100 MI = N; 0101 PL = ~N
  - 0110 VS = V; 0111 VC = ~V
  - 1000 HI = C&~Z; 1001 LS = ~C|Z
  - 1010 GE = N==V; 1011 LT = N!=V
  - 1100 GT = ~Z&(N==V); 1101 LE = Z|(N!=V)
  - 1110 AL = 1; 1111 = 1
- Let ce = in_valid & cond_met.
- Priority at each rising edge: flush > stall > normal.
- flush:
  - out_valid and all gated outputs are cleared to 0 next cycle.
  - No flag update and no counter change.
- stall (without flush):
  - All registers, including flags and squash_cnt, hold their values.
  - The incoming instruction is not consumed.
- Normal operation:
  - out_valid <= in_valid; cond_ex <= ce.
  - pcs <= ce & pcs_in.
  - reg_write <= ce & reg_w_in & ~no_write_in.
  - mem_write <= ce & mem_w_in.
  - If ce & flag_w[1]: flags[3:2] <= alu_flags[3:2].
  - If ce & flag_w[0]: flags[1:0] <= alu_flags[1:0].
  - If in_valid & ~cond_met: squash_cnt increments, saturating at all-ones with no wrap.
- Output latency is exactly one cycle. flags update on the same edge, so the next instruction sees the new flags.
- When in_valid=0, the gated outputs are 0 and flags are unchanged regardless of flag_w.
- alu_flags X/garbage is ignored whenever ce=0 or flag_w=00.

Decomposition:
- Shared package cond_pkg:
  - typedef cond_e with the 16 codes (EQ..AL, NV).
  - typedef flags_t, a packed struct {n,z,c,v}.
  - Index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One purely combinational sub-module, cond_check (cond, flags -> cond_met), reused by future pipelined variants.
- Flag register, output stage and counter stay in the top module.

Test Plan:
- Reset with FLAG_RST=0: cond=0000 (EQ), in_valid=1, reg_w_in=1 -> next cycle reg_write=0, cond_ex=0, squash_cnt=1.
- CMP-like flag_w=11, alu_flags=0100, cond=1110, no_write_in=1, reg_w_in=1 -> flags=0100, reg_write=0, cond_ex=1. Next instruction with cond=0000 -> reg_write=1.
- Partial update: flags=1111, flag_w=10, alu_flags=0000, cond=AL -> flags=0011. With cond=1010 (GE) next -> cond_met=0 because N=0 and V=1.
- Stall with in_valid=1, cond=AL, flag_w=11, alu_flags=1000 for 3 cycles -> flags and outputs unchanged. On release -> flags=1000.
- Flush and stall asserted together with a valid AL store -> mem_write=0, out_valid=0, flags unchanged.
- Counter saturation, CNT_W=2: 5 failed valid instructions -> squash_cnt stays at 3. Reset mid-run -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and constants for the ARM condition/flag logic.
// Flag bit ordering is {N,Z,C,V} throughout.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition-code evaluator.
// NV is treated as always-true, matching the behaviour of AL.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_met
);

    always_comb begin
        cond_met = 1'b1;
        unique case (cond_e'(cond))
            COND_EQ: cond_met = flags.z;
            COND_NE: cond_met = ~flags.z;
            COND_CS: cond_met = flags.c;
            COND_CC: cond_met = ~flags.c;
            COND_MI: cond_met = flags.n;
            COND_PL: cond_met = ~flags.n;
            COND_VS: cond_met = flags.v;
            COND_VC: cond_met = ~flags.v;
            COND_HI: cond_met = flags.c & ~flags.z;
            COND_LS: cond_met = ~flags.c | flags.z;
            COND_GE: cond_met = (flags.n == flags.v);
            COND_LT: cond_met = (flags.n != flags.v);
            COND_GT: cond_met = ~flags.z & (flags.n == flags.v);
            COND_LE: cond_met = flags.z | (flags.n != flags.v);
            COND_AL: cond_met = 1'b1;
            COND_NV: cond_met = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag register plus condition gating of PCS/RegWrite/MemWrite strobes.
// Outputs are registered (one-cycle latency); flush beats stall beats normal.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs_in,
    input  logic             reg_w_in,
    input  logic             mem_w_in,
    input  logic             no_write_in,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic             cond_ex,
    output logic             pcs,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0] flags_reg;
    logic       cond_met;
    logic       ce;

    // Evaluated against the committed flags only, so an instruction never
    // observes its own ALU flag result.
    cond_check u_cond_check (
        .cond     (cond),
        .flags    (flags_t'(flags_reg)),
        .cond_met (cond_met)
    );

    assign ce    = in_valid & cond_met;
    assign flags = flags_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pcs       <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pcs       <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            cond_ex   <= ce;
            pcs       <= ce & pcs_in;
            reg_write <= ce & reg_w_in & ~no_write_in;
            mem_write <= ce & mem_w_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= FLAG_RST;
        end else if (!flush && !stall && ce) begin
            if (flag_w[1])
                flags_reg[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
            if (flag_w[0])
                flags_reg[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
        end
    end

    // Saturates rather than wraps so a long run of skipped code stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_cnt <= '0;
        end else if (!flush && !stall && in_valid && !cond_met) begin
            if (squash_cnt != {CNT_W{1'b1}})
                squash_cnt <= squash_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomised + directed bench for cond_flag_unit against a behavioural model.
module tb_cond_flag_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  cond = 4'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic [1:0]  flag_w = 2'b00;
    logic        pcs_in = 1'b0, reg_w_in = 1'b0, mem_w_in = 1'b0, no_write_in = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;

    logic        out_valid, cond_ex, pcs, reg_write, mem_write;
    logic [3:0]  flags;
    logic [15:0] squash_cnt;

    logic        s_out_valid, s_cond_ex, s_pcs, s_reg_write, s_mem_write;
    logic [3:0]  s_flags;
    logic [1:0]  s_squash_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cond_flag_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs_in(pcs_in),
        .reg_w_in(reg_w_in), .mem_w_in(mem_w_in), .no_write_in(no_write_in),
        .stall(stall), .flush(flush), .out_valid(out_valid), .cond_ex(cond_ex),
        .pcs(pcs), .reg_write(reg_write), .mem_write(mem_write),
        .flags(flags), .squash_cnt(squash_cnt)
    );

    cond_flag_unit #(.FLAG_RST(4'b0000), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs_in(pcs_in),
        .reg_w_in(reg_w_in), .mem_w_in(mem_w_in), .no_write_in(no_write_in),
        .stall(stall), .flush(flush), .out_valid(s_out_valid), .cond_ex(s_cond_ex),
        .pcs(s_pcs), .reg_write(s_reg_write), .mem_write(s_mem_write),
        .flags(s_flags), .squash_cnt(s_squash_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Condition table written directly from the ARM mnemonics.
    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Model state: what the outputs must be after each edge.
    bit       m_ov, m_ce, m_pcs, m_rw, m_mw;
    bit [3:0] m_flags;
    int       m_cnt16, m_cnt2;

    always begin
        @(posedge clk);
        if (reset) begin
            {m_ov, m_ce, m_pcs, m_rw, m_mw} = '0;
            m_flags = 4'b0000;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (flush) begin
            {m_ov, m_ce, m_pcs, m_rw, m_mw} = '0;
        end else if (!stall) begin
            bit met, ex;
            met  = model_cond(cond, m_flags);
            ex   = in_valid && met;
            m_ov = in_valid;
            m_ce = ex;
            m_pcs = ex && pcs_in;
            m_rw  = ex && reg_w_in && !no_write_in;
            m_mw  = ex && mem_w_in;
            if (ex && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
            if (ex && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
            if (in_valid && !met) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("cond_ex", cond_ex, m_ce);
        chk("pcs", pcs, m_pcs);
        chk("reg_write", reg_write, m_rw);
        chk("mem_write", mem_write, m_mw);
        chk("flags", flags, m_flags);
        chk("squash_cnt", squash_cnt, m_cnt16);
        chk("sat_squash_cnt", s_squash_cnt, m_cnt2);
        chk("sat_flags", s_flags, m_flags);
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic rw, input logic nw,
                         input logic mw, input logic st, input logic fl);
        @(negedge clk);
        in_valid = v; cond = c; flag_w = fw; alu_flags = af;
        reg_w_in = rw; no_write_in = nw; mem_w_in = mw; pcs_in = 1'b0;
        stall = st; flush = fl;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] hold_flags;
        logic       hold_ov, hold_ce;
        #1;
        chk("reset_flags", flags, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_squash", squash_cnt, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // EQ with Z=0 fails: no write, counted
        drive(1, 4'b0000, 2'b00, 4'h0, 1, 0, 0, 0, 0); settle();
        chk("eq_reg_write", reg_write, 1'b0);
        chk("eq_cond_ex", cond_ex, 1'b0);
        chk("eq_squash", squash_cnt, 16'd1);

        // CMP-like: sets Z, no register write
        drive(1, 4'b1110, 2'b11, 4'b0100, 1, 1, 0, 0, 0); settle();
        chk("cmp_flags", flags, 4'b0100);
        chk("cmp_reg_write", reg_write, 1'b0);
        chk("cmp_cond_ex", cond_ex, 1'b1);
        drive(1, 4'b0000, 2'b00, 4'h0, 1, 0, 0, 0, 0); settle();
        chk("eq_after_cmp", reg_write, 1'b1);

        // Partial update of N,Z only
        drive(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0, 0); settle();
        drive(1, 4'b1110, 2'b10, 4'b0000, 0, 0, 0, 0, 0); settle();
        chk("partial_flags", flags, 4'b0011);
        drive(1, 4'b1010, 2'b00, 4'h0, 1, 0, 0, 0, 0); settle();
        chk("ge_cond_ex", cond_ex, 1'b0);

        // Stall for three cycles, then release
        hold_flags = flags; hold_ov = out_valid; hold_ce = cond_ex;
        drive(1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 1, 0);
        repeat (3) settle();
        chk("stall_flags", flags, hold_flags);
        chk("stall_out_valid", out_valid, hold_ov);
        chk("stall_cond_ex", cond_ex, hold_ce);
        drive(1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0, 0); settle();
        chk("release_flags", flags, 4'b1000);

        // Flush beats stall on a valid AL store
        drive(1, 4'b1110, 2'b11, 4'b0110, 0, 0, 1, 1, 1); settle();
        chk("flush_mem_write", mem_write, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_flags", flags, 4'b1000);

        // Five failing EQ (Z=0): 2-bit counter saturates at 3
        repeat (5) drive(1, 4'b0000, 2'b00, 4'h0, 0, 0, 0, 0, 0);
        settle();
        chk("sat_counter", s_squash_cnt, 2'd3);
        chk("wide_counter", squash_cnt, 16'd7);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 299) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            cond        = 4'($urandom);
            alu_flags   = 4'($urandom);
            flag_w      = 2'($urandom);
            pcs_in      = 1'($urandom);
            reg_w_in    = 1'($urandom);
            mem_w_in    = 1'($urandom);
            no_write_in = 1'($urandom);
            stall       = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 11) == 0);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; cond = 4'b1110; flag_w = 2'b11; alu_flags = 4'b1111;
        mem_w_in = 1'b1; reg_w_in = 1'b1; no_write_in = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_flags", flags, 4'b0000);
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_mem_write", mem_write, 1'b0);
        chk("async_reg_write", reg_write, 1'b0);
        chk("async_squash", squash_cnt, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
